// File: rtl/commit_engine_if.sv
// Dispatch, writeback, retirement and committed-state signals of the commit engine.
// Master drives dispatch/writeback/stall; slave is the engine.
interface commit_engine_if #(
  parameter int ROB_DEPTH  = 64,
  parameter int DISPATCH_W = 3,
  parameter int COMMIT_W   = 4,
  parameter int WB_PORTS   = 6,
  parameter int PREG_BITS  = 6
);
  localparam int IDX_W = $clog2(ROB_DEPTH);

  logic [DISPATCH_W-1:0]           disp_valid;
  logic [DISPATCH_W-1:0]           disp_regwr;
  logic [DISPATCH_W-1:0]           disp_excp;
  logic [DISPATCH_W*5-1:0]         disp_rd;
  logic [DISPATCH_W*PREG_BITS-1:0] disp_pd;
  logic [DISPATCH_W*PREG_BITS-1:0] disp_pd_old;
  logic                            disp_ready;
  logic [DISPATCH_W*IDX_W-1:0]     disp_tag;
  logic [WB_PORTS-1:0]             wb_valid;
  logic [WB_PORTS-1:0]             wb_excp;
  logic [WB_PORTS-1:0]             wb_redirect;
  logic [WB_PORTS*IDX_W-1:0]       wb_tag;
  logic                            stall_in;
  logic [COMMIT_W-1:0]             cmt_valid;
  logic [COMMIT_W-1:0]             cmt_regwr;
  logic [COMMIT_W*5-1:0]           cmt_rd;
  logic [COMMIT_W*PREG_BITS-1:0]   cmt_pd;
  logic [COMMIT_W*PREG_BITS-1:0]   cmt_pd_old;
  logic                            flush;
  logic                            flush_excp;
  logic [IDX_W-1:0]                head_tag;
  logic [IDX_W:0]                  rob_count;
  logic [32*PREG_BITS-1:0]         arat_map;
  logic [(1<<PREG_BITS)-1:0]       arat_free;

  modport master (
    output disp_valid, disp_regwr, disp_excp, disp_rd, disp_pd, disp_pd_old,
    output wb_valid, wb_excp, wb_redirect, wb_tag, stall_in,
    input  disp_ready, disp_tag, cmt_valid, cmt_regwr, cmt_rd, cmt_pd, cmt_pd_old,
    input  flush, flush_excp, head_tag, rob_count, arat_map, arat_free
  );

  modport slave (
    input  disp_valid, disp_regwr, disp_excp, disp_rd, disp_pd, disp_pd_old,
    input  wb_valid, wb_excp, wb_redirect, wb_tag, stall_in,
    output disp_ready, disp_tag, cmt_valid, cmt_regwr, cmt_rd, cmt_pd, cmt_pd_old,
    output flush, flush_excp, head_tag, rob_count, arat_map, arat_free
  );
endinterface

// File: rtl/commit_engine.sv
// Reorder buffer with in-order retirement and a registered architectural rename map/free list.
// Retirement and flush are combinational from state (ARAT lags one cycle); dispatch held off by disp_ready.
module commit_engine #(
  parameter int ROB_DEPTH  = 64,
  parameter int DISPATCH_W = 3,
  parameter int COMMIT_W   = 4,
  parameter int WB_PORTS   = 6,
  parameter int PREG_BITS  = 6
) (
  input logic            clk,
  input logic            rst,
  commit_engine_if.slave bus
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int NPREG = 1 << PREG_BITS;

  logic [PTR_W-1:0]     r_head, r_tail, r_count;
  logic [ROB_DEPTH-1:0] r_vld, r_done, r_excp, r_redir, r_regwr;
  logic [4:0]           r_rd     [ROB_DEPTH];
  logic [PREG_BITS-1:0] r_pd     [ROB_DEPTH];
  logic [PREG_BITS-1:0] r_pd_old [ROB_DEPTH];
  logic [PREG_BITS-1:0] r_map    [32];
  logic [NPREG-1:0]     r_free;

  logic                 w_empty, w_disp_ready, w_go, w_flush, w_flush_excp;
  logic [PTR_W-1:0]     w_disp_n, w_ret_n;
  logic [COMMIT_W-1:0]  w_cmt_vld, w_cmt_regwr;
  logic [IDX_W-1:0]     w_cmt_idx  [COMMIT_W];
  logic [IDX_W-1:0]     w_disp_idx [DISPATCH_W];
  logic [ROB_DEPTH-1:0] w_wb_done, w_wb_excp, w_wb_redir;

  // Pointers carry a wrap bit, so equal full pointers means empty.
  assign w_empty      = (r_head == r_tail);
  assign w_disp_ready = (PTR_W'(ROB_DEPTH) - r_count) >= PTR_W'(DISPATCH_W);

  always_comb begin
    w_disp_n = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      w_disp_idx[i] = r_tail[IDX_W-1:0] + IDX_W'(i);
      if (w_disp_ready && bus.disp_valid[i]) w_disp_n = w_disp_n + PTR_W'(1);
    end
  end

  // Ports hitting the same tag must OR, so accumulate before the register update.
  always_comb begin
    w_wb_done  = '0;
    w_wb_excp  = '0;
    w_wb_redir = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p]) begin
        w_wb_done[bus.wb_tag[p*IDX_W +: IDX_W]]  = 1'b1;
        w_wb_excp[bus.wb_tag[p*IDX_W +: IDX_W]]  = w_wb_excp[bus.wb_tag[p*IDX_W +: IDX_W]]  | bus.wb_excp[p];
        w_wb_redir[bus.wb_tag[p*IDX_W +: IDX_W]] = w_wb_redir[bus.wb_tag[p*IDX_W +: IDX_W]] | bus.wb_redirect[p];
      end
    end
  end

  always_comb begin
    w_go         = ~bus.stall_in & ~w_empty;
    w_cmt_vld    = '0;
    w_cmt_regwr  = '0;
    w_flush      = 1'b0;
    w_flush_excp = 1'b0;
    w_ret_n      = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      w_cmt_idx[k] = r_head[IDX_W-1:0] + IDX_W'(k);
      if (w_go && r_vld[w_cmt_idx[k]] && r_done[w_cmt_idx[k]]) begin
        w_cmt_vld[k]   = 1'b1;
        w_cmt_regwr[k] = r_regwr[w_cmt_idx[k]] & ~r_excp[w_cmt_idx[k]];
        w_ret_n        = w_ret_n + PTR_W'(1);
        if (r_excp[w_cmt_idx[k]] || r_redir[w_cmt_idx[k]]) begin
          w_flush      = 1'b1;
          w_flush_excp = r_excp[w_cmt_idx[k]];
          w_go         = 1'b0;
        end
      end else begin
        w_go = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      r_head  <= r_head + w_ret_n;
      r_tail  <= r_tail + w_disp_n;
      r_count <= r_count + w_disp_n - w_ret_n;
      for (int k = 0; k < COMMIT_W; k++)
        if (w_cmt_vld[k]) r_vld[w_cmt_idx[k]] <= 1'b0;
      for (int i = 0; i < DISPATCH_W; i++)
        if (w_disp_ready && bus.disp_valid[i]) r_vld[w_disp_idx[i]] <= 1'b1;
    end
  end

  // Entry payload and status; only meaningful while the matching r_vld bit is set.
  always_ff @(posedge clk) begin
    r_done  <= r_done  | (w_wb_done  & r_vld);
    r_excp  <= r_excp  | (w_wb_excp  & r_vld);
    r_redir <= r_redir | (w_wb_redir & r_vld);
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (w_disp_ready && bus.disp_valid[i]) begin
        r_done[w_disp_idx[i]]   <= bus.disp_excp[i];
        r_excp[w_disp_idx[i]]   <= bus.disp_excp[i];
        r_redir[w_disp_idx[i]]  <= 1'b0;
        r_regwr[w_disp_idx[i]]  <= bus.disp_regwr[i];
        r_rd[w_disp_idx[i]]     <= bus.disp_rd[i*5 +: 5];
        r_pd[w_disp_idx[i]]     <= bus.disp_pd[i*PREG_BITS +: PREG_BITS];
        r_pd_old[w_disp_idx[i]] <= bus.disp_pd_old[i*PREG_BITS +: PREG_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_map[i] <= PREG_BITS'(i);
      r_free <= {{(NPREG-32){1'b1}}, 32'b0};
    end else begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (w_cmt_vld[k] && w_cmt_regwr[k] && (r_rd[w_cmt_idx[k]] != 5'd0)) begin
          r_map[r_rd[w_cmt_idx[k]]]  <= r_pd[w_cmt_idx[k]];
          r_free[r_pd[w_cmt_idx[k]]] <= 1'b0;
          r_free[r_pd_old[w_cmt_idx[k]]] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DISPATCH_W; i++) bus.disp_tag[i*IDX_W +: IDX_W] = w_disp_idx[i];
    for (int k = 0; k < COMMIT_W; k++) begin
      bus.cmt_rd[k*5 +: 5]                     = r_rd[w_cmt_idx[k]];
      bus.cmt_pd[k*PREG_BITS +: PREG_BITS]     = r_pd[w_cmt_idx[k]];
      bus.cmt_pd_old[k*PREG_BITS +: PREG_BITS] = r_pd_old[w_cmt_idx[k]];
    end
    for (int i = 0; i < 32; i++) bus.arat_map[i*PREG_BITS +: PREG_BITS] = r_map[i];
  end

  assign bus.disp_ready = w_disp_ready;
  assign bus.cmt_valid  = w_cmt_vld;
  assign bus.cmt_regwr  = w_cmt_regwr;
  assign bus.flush      = w_flush;
  assign bus.flush_excp = w_flush_excp;
  assign bus.head_tag   = r_head[IDX_W-1:0];
  assign bus.rob_count  = r_count;
  assign bus.arat_free  = r_free;
endmodule

// File: doc/commit_engine.md
COMMIT_ENGINE -- requirements
Module: commit_engine

Interface
REQ-001 SHALL take parameter ROB_DEPTH, default 64, ROB entry count, power of two, 8..128.
REQ-002 SHALL take parameter DISPATCH_W, default 3, instructions accepted per cycle.
REQ-003 SHALL take parameter COMMIT_W, default 4, instructions retired per cycle, 1..8.
REQ-004 SHALL take parameter WB_PORTS, default 6, completion ports.
REQ-005 SHALL take parameter PREG_BITS, default 6, physical register index width; IDX_W = log2(ROB_DEPTH).
REQ-006 SHALL provide ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- disp_valid  in  DISPATCH_W  dispatch lane valid; set lanes contiguous from lane 0
- disp_regwr / disp_excp  in  DISPATCH_W each  writes Rd / exception detected at decode
- disp_rd  in  DISPATCH_W*5  architectural destination
- disp_pd / disp_pd_old  in  DISPATCH_W*PREG_BITS each  new / previous physical mapping
- disp_ready  out  1  free entries >= DISPATCH_W
- disp_tag  out  DISPATCH_W*IDX_W  tag of lane i = tail+i
- wb_valid / wb_excp / wb_redirect  in  WB_PORTS each  completion, exception, branch redirect
- wb_tag  in  WB_PORTS*IDX_W  completing entry
- stall_in  in  1  freeze retirement
- cmt_valid / cmt_regwr  out  COMMIT_W each  lane retires / writes architectural state
- cmt_rd, cmt_pd, cmt_pd_old  out  per-lane fields of retiring entry
- flush / flush_excp  out  1 each  pipeline flush; cause is exception (1) or redirect (0)
- head_tag  out  IDX_W  oldest entry tag
- rob_count  out  IDX_W+1  occupied entries
- arat_map  out  32*PREG_BITS  committed rename map
- arat_free  out  2**PREG_BITS  committed free list, 1 = free

Function
REQ-007 ROB SHALL be circular, head/tail pointers carrying a wrap bit; full when count == ROB_DEPTH, empty when count == 0.
REQ-008 Dispatch SHALL write all valid lanes at tail and advance tail by popcount(disp_valid) only when disp_ready=1; otherwise disp_valid SHALL be ignored and tail held.
REQ-009 disp_ready SHALL be combinational from registered count: ROB_DEPTH-count >= DISPATCH_W.
REQ-010 A valid wb_valid port SHALL set done for entry wb_tag next edge, OR-ing wb_excp and wb_redirect into its flags; writes to invalid entries SHALL be ignored; several ports to the same tag SHALL OR.
REQ-011 Retirement SHALL examine head..head+COMMIT_W-1 combinationally; lane k SHALL retire iff entries 0..k are valid and done, no earlier examined lane carries excp/redirect, and stall_in=0.
REQ-012 Entry with disp_excp set SHALL be treated as done at dispatch.
REQ-013 Exception entry SHALL retire with cmt_regwr=0 and assert flush=1, flush_excp=1 same cycle; redirect entry SHALL retire with its normal cmt_regwr and assert flush=1, flush_excp=0; exception takes priority when both flags set.
REQ-014 On flush edge all entries SHALL be invalidated, head=tail=0, count=0; dispatch and writeback in that cycle SHALL be discarded; ARAT SHALL still absorb that cycle's retirements.
REQ-015 count SHALL update as count + dispatched - retired, dispatch and retirement in one cycle both applied.
REQ-016 ARAT SHALL apply retiring lanes in lane order each edge: for cmt_regwr lane, map[rd]=pd, free[pd]=0, then free[pd_old]=1; a later lane overrides an earlier one.
REQ-017 Writes to rd=0 SHALL update neither map nor free list.
REQ-018 cmt_* and flush SHALL be combinational from registered state; arat_map/arat_free SHALL be registered (one-cycle latency after retirement).

Reset
REQ-019 With rst=0 at an edge: head=tail=0, count=0, all entries invalid, disp_ready=1, cmt_valid=0, flush=0, arat_map[i]=i, arat_free bits 0..31=0 and 32..2**PREG_BITS-1=1; reset mid-operation discards all in-flight entries.

Verification (ROB_DEPTH=16, DISPATCH_W=3, COMMIT_W=4)
REQ-020 Fill: dispatch 3/cycle, no wb -> tags 0..14 assigned, count=15, disp_ready=0 at count 14+, tail wraps to 0 after 16.
REQ-021 In-order retire: wb tags 2,1 then 0 -> nothing retires until tag0 done, then lanes 0..2 retire same cycle, head=3.
REQ-022 Exception: tag1 wb_excp, tags 0..3 done -> tag0,tag1 retire, tag1 cmt_regwr=0, flush=1 flush_excp=1, next cycle count=0, head=tail=0.
REQ-023 ARAT collision: lanes 0,1 both rd=5, pd=40 then pd=41 (pd_old=40) -> map[5]=41, free[40]=1, free[41]=0, original pd_old of lane 0 freed.
REQ-024 Stall/simultaneous: stall_in=1 with 4 done entries -> cmt_valid=0, dispatch continues; release -> 4 retire, 3 dispatch, count changes by -1.
REQ-025 Reset mid-run: rst=0 with count=9 -> next cycle count=0, arat_map identity, flush=0.
